// File: rtl/dmem_arb_pkg.sv
// Shared types and default widths for the data-memory arbiter.
package dmem_arb_pkg;

    localparam int unsigned DEF_ADDR_W = 32;
    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_RAM_AW = 10;

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_t;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_DMA  = 1'b1
    } owner_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester pair plus single-port RAM bundle; master = requesters/RAM side, slave = arbiter.
interface dmem_arbiter_if
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned RAM_AW = DEF_RAM_AW
) ();

    logic              c_req;
    logic              c_we;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic              c_gnt;
    logic              c_rvalid;
    logic [DATA_W-1:0] c_rdata;
    logic              c_stall;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic [RAM_AW-1:0] ram_addr;
    logic [DATA_W-1:0] ram_data;
    logic              ram_wren;
    logic              ram_rden;
    logic [DATA_W-1:0] ram_q;

    modport master (
        output c_req, c_we, c_addr, c_wdata,
        input  c_gnt, c_rvalid, c_rdata, c_stall,
        output d_req, d_we, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  ram_addr, ram_data, ram_wren, ram_rden,
        output ram_q
    );

    modport slave (
        input  c_req, c_we, c_addr, c_wdata,
        output c_gnt, c_rvalid, c_rdata, c_stall,
        input  d_req, d_we, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output ram_addr, ram_data, ram_wren, ram_rden,
        input  ram_q
    );

endinterface

// File: rtl/dmem_rr_pick.sv
// Two-way round-robin pick: a lone request wins, a conflict goes to whoever did not win last.
module dmem_rr_pick
    import dmem_arb_pkg::*;
(
    input  logic   req_c,
    input  logic   req_d,
    input  owner_t last_grant,
    output logic   gnt_c,
    output logic   gnt_d
);

    // Grant decode; never both high.
    always_comb begin
        gnt_c = req_c & (~req_d | (last_grant == OWN_DMA));
        gnt_d = req_d & (~req_c | (last_grant == OWN_CORE));
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Core / DMA arbiter in front of a single-port synchronous RAM with one-cycle read latency.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned RAM_AW = DEF_RAM_AW
) (
    input  logic           CLK,
    input  logic           RESET_N,
    dmem_arbiter_if.slave  bus
);

    state_t state, state_nxt;
    owner_t owner, owner_nxt;
    owner_t last_grant, last_grant_nxt;

    logic              idle_ok;
    logic              pick_c;
    logic              pick_d;
    logic [RAM_AW-1:0] ram_addr_nxt;
    logic [DATA_W-1:0] ram_data_nxt;
    logic              ram_wren_nxt;
    logic              ram_rden_nxt;
    logic              unused_addr_bits;

    // Grants are only possible in IDLE and never while reset is held.
    assign idle_ok = RESET_N & (state == IDLE);

    dmem_rr_pick u_pick (
        .req_c      (bus.c_req & idle_ok),
        .req_d      (bus.d_req & idle_ok),
        .last_grant (last_grant),
        .gnt_c      (pick_c),
        .gnt_d      (pick_d)
    );

    // Address bits above the RAM window and the byte offset are don't-care (accesses wrap).
    assign unused_addr_bits = ^{bus.c_addr[ADDR_W-1:RAM_AW+2], bus.c_addr[1:0],
                                bus.d_addr[ADDR_W-1:RAM_AW+2], bus.d_addr[1:0]};

    // State register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= IDLE;
            owner      <= OWN_CORE;
            last_grant <= OWN_DMA;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    // Next state and RAM strobes for the granted requester.
    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        last_grant_nxt = last_grant;
        ram_addr_nxt   = '0;
        ram_data_nxt   = '0;
        ram_wren_nxt   = 1'b0;
        ram_rden_nxt   = 1'b0;

        if (state == RD_WAIT) begin
            state_nxt = IDLE;
        end

        if (pick_c) begin
            last_grant_nxt = OWN_CORE;
            ram_addr_nxt   = bus.c_addr[RAM_AW+1:2];
            if (bus.c_we) begin
                ram_wren_nxt = 1'b1;
                ram_data_nxt = bus.c_wdata;
            end else begin
                ram_rden_nxt = 1'b1;
                state_nxt    = RD_WAIT;
                owner_nxt    = OWN_CORE;
            end
        end else if (pick_d) begin
            last_grant_nxt = OWN_DMA;
            ram_addr_nxt   = bus.d_addr[RAM_AW+1:2];
            if (bus.d_we) begin
                ram_wren_nxt = 1'b1;
                ram_data_nxt = bus.d_wdata;
            end else begin
                ram_rden_nxt = 1'b1;
                state_nxt    = RD_WAIT;
                owner_nxt    = OWN_DMA;
            end
        end
    end

    // Requester-facing outputs; read data is steered only to the owner during RD_WAIT.
    always_comb begin
        bus.c_gnt    = pick_c;
        bus.d_gnt    = pick_d;
        bus.c_stall  = RESET_N & bus.c_req & ~pick_c;
        bus.c_rvalid = (state == RD_WAIT) && (owner == OWN_CORE);
        bus.d_rvalid = (state == RD_WAIT) && (owner == OWN_DMA);
        bus.c_rdata  = bus.c_rvalid ? bus.ram_q : '0;
        bus.d_rdata  = bus.d_rvalid ? bus.ram_q : '0;
        bus.ram_addr = ram_addr_nxt;
        bus.ram_data = ram_data_nxt;
        bus.ram_wren = ram_wren_nxt;
        bus.ram_rden = ram_rden_nxt;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a cycle-level reference model and a RAM model.
module tb_dmem_arbiter;

    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned RAM_AW    = 10;
    localparam int unsigned RAM_WORDS = 1 << RAM_AW;

    logic clk;
    logic rst_n;

    int checks = 0;
    int errors = 0;

    dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RAM_AW(RAM_AW)) bus ();

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RAM_AW(RAM_AW)) u_dut (
        .CLK     (clk),
        .RESET_N (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Physical RAM: write on wren, registered read data one cycle after rden.
    logic [DATA_W-1:0] ram_mem [RAM_WORDS];
    initial begin
        for (int i = 0; i < int'(RAM_WORDS); i++) ram_mem[i] = '0;
        bus.ram_q = '0;
    end
    always @(posedge clk) begin
        if (bus.ram_wren) ram_mem[bus.ram_addr] <= bus.ram_data;
        if (bus.ram_rden) bus.ram_q <= ram_mem[bus.ram_addr];
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: memory contents, pending read owner, and who wins the next conflict.
    logic [DATA_W-1:0] exp_mem [RAM_WORDS];
    bit                m_busy        = 1'b0;
    bit                m_owner_dma   = 1'b0;
    bit                m_prefer_core = 1'b1;
    logic [DATA_W-1:0] m_rd          = '0;
    initial for (int i = 0; i < int'(RAM_WORDS); i++) exp_mem[i] = '0;

    // Per-cycle compare, sampled mid-cycle after inputs settle, then model advances one edge.
    always begin
        bit                e_cg, e_dg, e_cv, e_dv, e_we, e_re, e_st, chk_data, win_c, win_d, we;
        logic [DATA_W-1:0] e_cr, e_dr, e_rd, wd;
        logic [ADDR_W-1:0] addr;
        int unsigned       word;
        int unsigned       e_ra;
        @(negedge clk);
        #2;
        e_cg = 0; e_dg = 0; e_cv = 0; e_dv = 0; e_we = 0; e_re = 0; chk_data = 1;
        e_cr = '0; e_dr = '0; e_rd = '0; e_ra = 0;
        if (!rst_n) begin
            m_busy        = 1'b0;
            m_prefer_core = 1'b1;
        end else if (m_busy) begin
            if (m_owner_dma) begin e_dv = 1; e_dr = m_rd; end
            else             begin e_cv = 1; e_cr = m_rd; end
            m_busy = 1'b0;
        end else begin
            win_c = bus.c_req && (!bus.d_req || m_prefer_core);
            win_d = bus.d_req && !win_c;
            if (win_c || win_d) begin
                e_cg = win_c;
                e_dg = win_d;
                we   = win_c ? bus.c_we    : bus.d_we;
                addr = win_c ? bus.c_addr  : bus.d_addr;
                wd   = win_c ? bus.c_wdata : bus.d_wdata;
                word = (int'(addr) / 4) % int'(RAM_WORDS);
                e_ra = word;
                m_prefer_core = win_d;
                if (we) begin
                    e_we = 1;
                    e_rd = wd;
                    exp_mem[word] = wd;
                end else begin
                    e_re = 1;
                    chk_data = 0;
                    m_busy = 1'b1;
                    m_owner_dma = win_d;
                    m_rd = exp_mem[word];
                end
            end
        end
        e_st = rst_n && bus.c_req && !e_cg;
        chk("c_gnt",    bus.c_gnt,    e_cg);
        chk("d_gnt",    bus.d_gnt,    e_dg);
        chk("c_rvalid", bus.c_rvalid, e_cv);
        chk("d_rvalid", bus.d_rvalid, e_dv);
        chk("c_rdata",  bus.c_rdata,  e_cr);
        chk("d_rdata",  bus.d_rdata,  e_dr);
        chk("ram_wren", bus.ram_wren, e_we);
        chk("ram_rden", bus.ram_rden, e_re);
        chk("ram_addr", bus.ram_addr, e_ra);
        chk("c_stall",  bus.c_stall,  e_st);
        if (chk_data) chk("ram_data", bus.ram_data, e_rd);
    end

    // Apply one cycle of stimulus at the falling edge; caller checks literals right after.
    task automatic drive(input logic r,
                         input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                         input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd);
        @(negedge clk);
        rst_n       = r;
        bus.c_req   = cr; bus.c_we = cw; bus.c_addr = ca; bus.c_wdata = cd;
        bus.d_req   = dr; bus.d_we = dw; bus.d_addr = da; bus.d_wdata = dd;
        #3;
    endtask

    task automatic idle_cyc(input logic r);
        drive(r, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.c_req = 0; bus.c_we = 0; bus.c_addr = '0; bus.c_wdata = '0;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;

        // Reset holds everything at zero even with a request present.
        drive(0, 1, 1, 32'h10, 32'h1, 1, 1, 32'h14, 32'h2);
        chk("rst c_gnt", bus.c_gnt, 0);
        chk("rst ram_wren", bus.ram_wren, 0);
        chk("rst c_stall", bus.c_stall, 0);
        idle_cyc(0);

        // Core write in the first cycle after reset release.
        drive(1, 1, 1, 32'h10, 32'hA5A5A5A5, 0, 0, 32'h0, 32'h0);
        chk("wr c_gnt", bus.c_gnt, 1);
        chk("wr ram_wren", bus.ram_wren, 1);
        chk("wr ram_addr", bus.ram_addr, 4);
        chk("wr ram_data", bus.ram_data, 32'hA5A5A5A5);
        chk("wr c_stall", bus.c_stall, 0);

        // Core read of the same word, data one cycle later.
        drive(1, 1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0);
        chk("rd ram_rden", bus.ram_rden, 1);
        chk("rd ram_addr", bus.ram_addr, 4);
        idle_cyc(1);
        chk("rd c_rvalid", bus.c_rvalid, 1);
        chk("rd c_rdata", bus.c_rdata, 32'hA5A5A5A5);
        chk("rd d_rvalid", bus.d_rvalid, 0);
        idle_cyc(1);
        chk("rd c_rvalid once", bus.c_rvalid, 0);

        // Fresh reset so the first conflict goes to the core.
        idle_cyc(0);
        drive(1, 1, 1, 32'h20, 32'h11111111, 1, 1, 32'h24, 32'h22222222);
        chk("cf1 c_gnt", bus.c_gnt, 1);
        chk("cf1 ram_addr", bus.ram_addr, 8);
        drive(1, 1, 1, 32'h20, 32'h11111111, 1, 1, 32'h24, 32'h22222222);
        chk("cf2 d_gnt", bus.d_gnt, 1);
        chk("cf2 c_stall", bus.c_stall, 1);
        chk("cf2 ram_addr", bus.ram_addr, 9);
        drive(1, 1, 1, 32'h20, 32'h11111111, 1, 1, 32'h24, 32'h22222222);
        chk("cf3 c_gnt", bus.c_gnt, 1);
        chk("cf3 d_gnt", bus.d_gnt, 0);

        // A read blocks the other requester for one cycle.
        drive(1, 1, 0, 32'h20, 32'h0, 0, 0, 32'h0, 32'h0);
        chk("blk c_gnt", bus.c_gnt, 1);
        drive(1, 0, 0, 32'h0, 32'h0, 1, 0, 32'h24, 32'h0);
        chk("blk d_gnt N+1", bus.d_gnt, 0);
        chk("blk c_rdata", bus.c_rdata, 32'h11111111);
        drive(1, 0, 0, 32'h0, 32'h0, 1, 0, 32'h24, 32'h0);
        chk("blk d_gnt N+2", bus.d_gnt, 1);
        idle_cyc(1);
        chk("blk d_rdata", bus.d_rdata, 32'h22222222);
        chk("blk c_rdata zero", bus.c_rdata, 0);

        // High address bits wrap onto the same RAM word.
        drive(1, 0, 0, 32'h0, 32'h0, 1, 1, 32'h1010, 32'hDEADBEEF);
        chk("wrap ram_addr", bus.ram_addr, 4);
        drive(1, 1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0);
        // DMA request raised only during RD_WAIT and then dropped: no access.
        drive(1, 0, 0, 32'h0, 32'h0, 1, 1, 32'h30, 32'h33333333);
        chk("wrap c_rdata", bus.c_rdata, 32'hDEADBEEF);
        chk("drop d_gnt", bus.d_gnt, 0);
        idle_cyc(1);
        chk("drop ram_wren", bus.ram_wren, 0);
        chk("drop ram_rden", bus.ram_rden, 0);

        // Reset in RD_WAIT aborts the read.
        drive(1, 1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0);
        chk("abort grant", bus.c_gnt, 1);
        idle_cyc(0);
        chk("abort c_rvalid", bus.c_rvalid, 0);
        chk("abort c_rdata", bus.c_rdata, 0);
        drive(1, 1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0);
        chk("abort post c_gnt", bus.c_gnt, 1);
        chk("abort post c_rvalid", bus.c_rvalid, 0);
        idle_cyc(1);
        chk("abort post rdata", bus.c_rdata, 32'hDEADBEEF);
        idle_cyc(1);
        idle_cyc(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
